// File: rtl/insn_encoder.sv
// insn_encoder: field-level instruction descriptor -> RV32I word assembler and
// sequential instruction-memory loader, used for bring-up before core release.
//
// Optional build macro: INSN_ENCODER_JAL_EN (adds the J-type / JAL encoding for
// fmt 5; without it fmt 5 takes the illegal-descriptor path).
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start, i_finish   open a load session (pointer/counters cleared) / close it
//   i_valid, o_ready    descriptor handshake; o_ready is combinational
//   i_fmt, i_funct3, i_alt, i_rd, i_rs1, i_rs2, i_imm   descriptor fields
//   o_imem_we, o_imem_addr, o_imem_wdata                registered write port
//   o_count, o_full     words written this session, count reached DEPTH
//   o_err, o_err_cnt    sticky illegal flag, saturating reject count
//   o_done              session finished
module insn_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_finish,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_fmt,
  input  logic [2:0]        i_funct3,
  input  logic              i_alt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [20:0]       i_imm,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err,
  output logic [7:0]        o_err_cnt,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef INSN_ENCODER_JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              legal;
  logic [31:0]       word;
  logic              fit12, fit13, is_shift;

  assign o_full  = (o_count == DEPTH_C);
  assign o_done  = (state == DONE);
  // i_start masks acceptance so a restart never races a write into the new session
  assign o_ready = (state == RUN) & ~o_full & ~i_start;
  assign accept  = i_valid & o_ready;

  // Signed-fit: every bit above the target sign bit must copy it.
  assign fit12    = (&i_imm[20:11]) | ~(|i_imm[20:11]);
  assign fit13    = (&i_imm[20:12]) | ~(|i_imm[20:12]);
  assign is_shift = (i_funct3 == 3'b001) | (i_funct3 == 3'b101);

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (i_fmt)
      3'd0: begin
        legal = ~i_alt | (i_funct3 == 3'b000) | (i_funct3 == 3'b101);
        word  = {1'b0, i_alt, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      end
      3'd1: begin
        if (is_shift) begin
          // shamt lives in imm[4:0]; upper immediate bits are don't-care here
          legal = ~i_alt | (i_funct3 == 3'b101);
          word  = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_IMM};
        end else begin
          legal = fit12;
          word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM};
        end
      end
      3'd2: begin
        legal = fit12 & (i_funct3 != 3'b011) & (i_funct3 != 3'b110) & (i_funct3 != 3'b111);
        word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
      end
      3'd3: begin
        legal = fit12 & (i_funct3 <= 3'b010);
        word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
      end
      3'd4: begin
        legal = fit13 & ~i_imm[0] & (i_funct3 != 3'b010) & (i_funct3 != 3'b011);
        word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OP_BRANCH};
      end
`ifdef INSN_ENCODER_JAL_EN
      3'd5: begin
        // 21-bit field always fits; only halfword alignment can fail
        legal = ~i_imm[0];
        word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      end
`endif
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (i_start) state_nxt = RUN;
               else if (i_finish) state_nxt = DONE;
      DONE:    if (i_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr          <= BASE_C;
      o_count      <= '0;
      o_err        <= 1'b0;
      o_err_cnt    <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
    end else begin
      o_imem_we <= accept & legal;
      if (accept & legal) begin
        o_imem_addr  <= ptr;
        o_imem_wdata <= word;
        ptr          <= ptr + 1'b1;
        o_count      <= o_count + 1'b1;
      end
      if (accept & ~legal) begin
        o_err <= 1'b1;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
      end
      // never coincides with an acceptance (o_ready is masked by i_start)
      if (i_start) begin
        ptr       <= BASE_C;
        o_count   <= '0;
        o_err     <= 1'b0;
        o_err_cnt <= '0;
      end
    end
  end

endmodule
